// File: rtl/piso_ctrl_pkg.sv
// Shared encodings and sizing helpers for the framed PISO transmit controller.
package piso_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } state_e;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_tick_timer.sv
// Bit-period down-counter: tick_c marks the last clock of each BIT_CYCLES period.
module bit_tick_timer
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned   TW     = cnt_width(BIT_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] cnt;

  // Reload on clear or at terminal count so the next period starts cleanly.
  always_ff @(posedge clk) begin
    if (rst || clr || tick_c) cnt <= RELOAD;
    else                      cnt <= cnt - TW'(1);
  end

  assign tick_c = (cnt == '0);

endmodule

// File: rtl/piso_frame_tx_ctrl.sv
// Framed serial transmitter: accepts a word, sends start bit, WIDTH data bits MSB first, stop bit.
module piso_frame_tx_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic             serial_n, busy_n, done_n, ready_n;
  logic             tick_c;
  logic             timer_clr_c;

  assign timer_clr_c = (state == S_IDLE);

  bit_tick_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr_c),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      serial_out <= LINE_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_n;
      shift_reg  <= shift_n;
      bit_cnt    <= bit_n;
      serial_out <= serial_n;
      busy       <= busy_n;
      done       <= done_n;
      in_ready   <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    bit_n   = bit_cnt;

    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          shift_n = in_data;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick_c) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shift_n = {shift_reg[WIDTH-2:0], 1'b0};
          if (bit_cnt == LAST_BIT) state_n = S_STOP;
          else                     bit_n   = bit_cnt + BW'(1);
        end
      end
      S_STOP: begin
        if (tick_c) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    unique case (state_n)
      S_START: serial_n = 1'b0;
      S_DATA:  serial_n = shift_n[WIDTH-1];
      default: serial_n = LINE_IDLE;
    endcase
    busy_n  = (state_n != S_IDLE);
    ready_n = (state_n == S_IDLE);
    done_n  = (state == S_STOP) && (state_n == S_IDLE);
  end

endmodule

// File: tb/tb_piso_frame_tx_ctrl.sv
// Directed bench for piso_frame_tx_ctrl: BIT_CYCLES=1 and BIT_CYCLES=3 instances.
module tb_piso_frame_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dat1, dat3;
  logic       vld1, vld3;
  logic       rdy1, ser1, busy1, done1;
  logic       rdy3, ser3, busy3, done3;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  piso_frame_tx_ctrl #(.WIDTH(4), .BIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(dat1), .in_valid(vld1),
    .in_ready(rdy1), .serial_out(ser1), .busy(busy1), .done(done1)
  );

  piso_frame_tx_ctrl #(.WIDTH(4), .BIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(dat3), .in_valid(vld3),
    .in_ready(rdy3), .serial_out(ser3), .busy(busy3), .done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic exp1(input string tag, input logic s, input logic b, input logic d, input logic r);
    chk({tag, "_ser"},   ser1,  s);
    chk({tag, "_busy"},  busy1, b);
    chk({tag, "_done"},  done1, d);
    chk({tag, "_ready"}, rdy1,  r);
  endtask

  task automatic exp3(input string tag, input logic s, input logic b, input logic d, input logic r);
    chk({tag, "_ser"},   ser3,  s);
    chk({tag, "_busy"},  busy3, b);
    chk({tag, "_done"},  done3, d);
    chk({tag, "_ready"}, rdy3,  r);
  endtask

  initial begin
    logic [5:0]  s6;
    logic [17:0] s18;

    rst = 1'b1; vld1 = 1'b0; vld3 = 1'b0; dat1 = 4'h0; dat3 = 4'h0;

    // Reset then idle
    tick(); exp1("rst_a", 1'b1, 1'b0, 1'b0, 1'b1); exp3("rst3_a", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); exp1("rst_b", 1'b1, 1'b0, 1'b0, 1'b1); exp3("rst3_b", 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tick(); exp1("idle_a", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); exp1("idle_b", 1'b1, 1'b0, 1'b0, 1'b1);

    // Single frame 1101; in_data changed while busy must not matter
    vld1 = 1'b1; dat1 = 4'b1101;
    tick();
    vld1 = 1'b0; dat1 = 4'b0010;
    s6 = 6'b011011;
    for (int i = 0; i < 6; i++) begin
      exp1($sformatf("f1_bit%0d", i), s6[5-i], 1'b1, 1'b0, 1'b0);
      if (i == 2) dat1 = 4'b0100;
      tick();
    end
    exp1("f1_done", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    exp1("f1_after", 1'b1, 1'b0, 1'b0, 1'b1);

    // Back-to-back with in_valid held high
    vld1 = 1'b1; dat1 = 4'b1010;
    tick();
    dat1 = 4'b0101;
    s6 = 6'b010101;
    for (int i = 0; i < 6; i++) begin
      exp1($sformatf("b2b_a_bit%0d", i), s6[5-i], 1'b1, 1'b0, 1'b0);
      tick();
    end
    exp1("b2b_gap", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    vld1 = 1'b0;
    s6 = 6'b001011;
    for (int i = 0; i < 6; i++) begin
      exp1($sformatf("b2b_b_bit%0d", i), s6[5-i], 1'b1, 1'b0, 1'b0);
      tick();
    end
    exp1("b2b_done", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();

    // Mid-frame reset during second data bit, with in_valid also high
    vld1 = 1'b1; dat1 = 4'b1101;
    tick();
    vld1 = 1'b0;
    exp1("mr_start", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    exp1("mr_d0", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    exp1("mr_d1", 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    exp1("mr_abort", 1'b1, 1'b0, 1'b0, 1'b1);
    vld1 = 1'b1; dat1 = 4'b1111;
    tick();
    exp1("mr_rst_wins", 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b0; vld1 = 1'b0;
    tick();
    exp1("mr_no_done_a", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    exp1("mr_no_done_b", 1'b1, 1'b0, 1'b0, 1'b1);
    vld1 = 1'b1; dat1 = 4'b0011;
    tick();
    vld1 = 1'b0;
    s6 = 6'b000111;
    for (int i = 0; i < 6; i++) begin
      exp1($sformatf("mr_new_bit%0d", i), s6[5-i], 1'b1, 1'b0, 1'b0);
      tick();
    end
    exp1("mr_new_done", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();

    // Bit stretching, BIT_CYCLES=3, word 1000
    exp3("bs_idle", 1'b1, 1'b0, 1'b0, 1'b1);
    vld3 = 1'b1; dat3 = 4'b1000;
    tick();
    vld3 = 1'b0; dat3 = 4'b1111;
    s18 = 18'b000_111_000000000_111;
    for (int i = 0; i < 18; i++) begin
      exp3($sformatf("bs_cyc%0d", i), s18[17-i], 1'b1, 1'b0, 1'b0);
      tick();
    end
    exp3("bs_done", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    exp3("bs_after", 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx_ctrl.md
Name: piso_frame_tx_ctrl

Overview:
- Controller that sequences a parallel-in/serial-out shift datapath into framed serial transmission.
- Accepts a parallel word via valid/ready handshake, loads it into an internal WIDTH-bit shift register, then emits start bit, WIDTH data bits (MSB first) and stop bit on serial_out.
- Each bit is held for BIT_CYCLES clocks.
- Sits between a word producer and a single-wire serial link; replaces manual load/rst sequencing of the bare PISO.

Parameters:
- WIDTH, 4: data word width in bits (>=2).
- BIT_CYCLES, 1: clocks each serial bit is held (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word this cycle.
- serial_out  output  1  framed serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse on frame completion.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset, sampled at a rising edge with rst=1:
  - state=IDLE, shift_reg=0, bit_cnt=0, tick_cnt=0.
  - serial_out=1, busy=0, done=0, in_ready=1 from the following cycle.
- All outputs are registered or decoded from registered state only. No combinational path from in_valid to any output.
- in_ready=1 only in IDLE. A transfer occurs at a rising edge with in_valid&&in_ready.
  - in_data is captured into shift_reg.
  - Next state is START.
  - in_data is ignored at all other times.
- States IDLE, START, DATA, STOP; tick_cnt counts 0..BIT_CYCLES-1 within each bit.
  - IDLE: serial_out=1. On transfer go to START with tick_cnt=0.
  - START: serial_out=0 for BIT_CYCLES cycles, then go to DATA with bit_cnt=0.
  - DATA: serial_out=shift_reg[WIDTH-1]. At the end of each bit period, shift_reg shifts left, filling 0, and bit_cnt increments. After bit_cnt reaches WIDTH-1 and its period ends, go to STOP.
  - STOP: serial_out=1 for BIT_CYCLES cycles, then go to IDLE.
- done=1 exactly in the first IDLE cycle after STOP, and only then. in_ready is also 1 in that cycle.
- Minimum inter-frame gap is 1 idle cycle: a word accepted in the done cycle starts its START bit on the next cycle.
- Latency: transfer at edge k puts the start bit on serial_out from cycle k+1. The frame occupies exactly (WIDTH+2)*BIT_CYCLES cycles, followed by the done cycle.
- busy=1 in START, DATA and STOP.
- in_valid held high while busy: no effect on state. The word is accepted on the first cycle in_ready=1.
- rst asserted mid-frame (any state, any tick):
  - Frame aborts; IDLE next cycle with serial_out=1.
  - done is not pulsed.
  - The partial word is discarded.
- rst and in_valid both high on the same edge: rst wins; no transfer.
- Counter widths: bit_cnt is clog2(WIDTH) bits; tick_cnt is max(1, clog2(BIT_CYCLES)) bits. Neither counter wraps past its terminal value.

Decomposition:
- Shared package piso_ctrl_pkg holds the state encoding constants ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3, and the idle/stop line level constant LINE_IDLE=1'b1.
- One sub-module is natural: bit_tick_timer. It is a BIT_CYCLES down-counter with clear input and a one-cycle terminal-count output, used by the FSM to end each bit period.
- The shift register and bit counter stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> serial_out=1, busy=0, done=0, in_ready=1 throughout.
- Single frame, WIDTH=4, BIT_CYCLES=1: in_data=4'b1101, one-cycle valid -> serial_out 0,1,1,0,1,1 on cycles k+1..k+6; done=1 on k+7; busy=1 on k+1..k+6.
- Bit stretching, BIT_CYCLES=3: in_data=4'b1000 -> serial_out 0x3, 1x3, 0x9, 1x3 (18 cycles); done once after.
- Back-to-back: in_valid held high with 4'b1010 then 4'b0101 -> second word accepted exactly on the done cycle of the first; in_ready=0 during the frame; stream 0,1,0,1,0,1,(1),0,0,1,0,1,1.
- Mid-frame reset: reset asserted on the second DATA bit of 4'b1101 -> serial_out=1 and state IDLE next cycle; no done pulse; a new word 4'b0011 then transmits correctly as 0,0,0,1,1,1.
- Held data: change in_data while busy -> transmitted bits unchanged from the captured word.
